// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit_pkg
// Purpose  : Op encodings, exception codes, FSM states and op helpers.
// Revision : 1.0
// ============================================================================
package mem_access_unit_pkg;

    localparam logic [3:0] OP_NONE = 4'd0;
    localparam logic [3:0] OP_LB   = 4'd1;
    localparam logic [3:0] OP_LBU  = 4'd2;
    localparam logic [3:0] OP_LH   = 4'd3;
    localparam logic [3:0] OP_LHU  = 4'd4;
    localparam logic [3:0] OP_LW   = 4'd5;
    localparam logic [3:0] OP_LWL  = 4'd6;
    localparam logic [3:0] OP_LWR  = 4'd7;
    localparam logic [3:0] OP_SB   = 4'd8;
    localparam logic [3:0] OP_SH   = 4'd9;
    localparam logic [3:0] OP_SW   = 4'd10;
    localparam logic [3:0] OP_SWL  = 4'd11;
    localparam logic [3:0] OP_SWR  = 4'd12;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    function automatic logic op_is_store(input logic [3:0] op);
        return op inside {OP_SB, OP_SH, OP_SW, OP_SWL, OP_SWR};
    endfunction

    function automatic logic op_is_load(input logic [3:0] op);
        return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR};
    endfunction

    function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] addr_lo);
        if (op inside {OP_LH, OP_LHU, OP_SH}) return addr_lo[0];
        if (op inside {OP_LW, OP_SW})         return addr_lo != 2'b00;
        return 1'b0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_lane.sv
`default_nettype none
// ============================================================================
// Module   : mem_lane_align
// Purpose  : Byte-lane steering: store strobes/data and load formatting.
// Revision : 1.0
// ============================================================================
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_lanes,
    output logic [31:0] rdata_fmt
);

    logic [4:0]  w_sh;
    logic [4:0]  w_shc;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_keep_l;
    logic [31:0] w_keep_r;

    // w_sh = 8*k, w_shc = 8*(3-k)
    assign w_sh     = {addr_lo, 3'b000};
    assign w_shc    = {~addr_lo, 3'b000};
    assign w_byte   = 8'(rdata >> w_sh);
    assign w_half   = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    assign w_keep_l = 32'h00FF_FFFF >> w_sh;
    assign w_keep_r = ~(32'hFFFF_FFFF >> w_sh);

    always_comb begin
        wstrb       = 4'b0000;
        wdata_lanes = 32'h0;
        case (op)
            OP_SB: begin
                wstrb       = 4'b0001 << addr_lo;
                wdata_lanes = {24'h0, wdata[7:0]} << w_sh;
            end
            OP_SH: begin
                wstrb       = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = addr_lo[1] ? {wdata[15:0], 16'h0} : {16'h0, wdata[15:0]};
            end
            OP_SW: begin
                wstrb       = 4'b1111;
                wdata_lanes = wdata;
            end
            OP_SWL: begin
                wstrb       = 4'b1111 >> ~addr_lo;
                wdata_lanes = wdata >> w_shc;
            end
            OP_SWR: begin
                wstrb       = 4'b1111 << addr_lo;
                wdata_lanes = wdata << w_sh;
            end
            default: ;
        endcase
    end

    // For LWL/LWR, wdata carries the old rt value that unaddressed bytes keep.
    always_comb begin
        rdata_fmt = 32'h0;
        case (op)
            OP_LB:   rdata_fmt = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  rdata_fmt = {24'h0, w_byte};
            OP_LH:   rdata_fmt = {{16{w_half[15]}}, w_half};
            OP_LHU:  rdata_fmt = {16'h0, w_half};
            OP_LW:   rdata_fmt = rdata;
            OP_LWL:  rdata_fmt = (rdata << w_shc) | (wdata & w_keep_l);
            OP_LWR:  rdata_fmt = (rdata >> w_sh) | (wdata & w_keep_r);
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : Single-outstanding load/store unit with alignment checks.
// Revision : 1.0
// ============================================================================
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TAG_W  = 64,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [31:0]       in_wdata,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic              flush,
    output logic              dm_req,
    output logic              dm_wr,
    output logic [3:0]        dm_wstrb,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_wdata,
    input  logic              dm_addr_ok,
    input  logic              dm_data_ok,
    input  logic [31:0]       dm_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_result,
    output logic [TAG_W-1:0]  out_tag,
    output logic [4:0]        out_exc,
    output logic [ADDR_W-1:0] out_badvaddr
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_result;
    logic [TAG_W-1:0]  r_tag;
    logic [4:0]        r_exc;

    logic        w_fault;
    logic        w_to_req;
    logic        w_accept;
    logic        w_take_data;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wlanes;
    logic [31:0] w_rfmt;

    mem_lane_align u_lane (
        .op          (r_op),
        .addr_lo     (r_addr[1:0]),
        .wdata       (r_wdata),
        .rdata       (dm_rdata),
        .wstrb       (w_wstrb),
        .wdata_lanes (w_wlanes),
        .rdata_fmt   (w_rfmt)
    );

    assign w_fault     = op_misaligned(in_op, in_addr[1:0]);
    assign w_to_req    = (op_is_load(in_op) || op_is_store(in_op)) && !w_fault;
    assign in_ready    = !flush && ((r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready));
    assign w_accept    = in_valid && in_ready;
    assign w_take_data = (r_state == ST_WAIT) && dm_data_ok && !flush;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_nxt = w_to_req ? ST_REQ : ST_DONE;
            end
            ST_REQ: begin
                // A flush racing an accepted request still owes us a response.
                if (flush)           w_state_nxt = dm_addr_ok ? ST_DRAIN : ST_IDLE;
                else if (dm_addr_ok) w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (flush)           w_state_nxt = dm_data_ok ? ST_IDLE : ST_DRAIN;
                else if (dm_data_ok) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (flush)          w_state_nxt = ST_IDLE;
                else if (w_accept)  w_state_nxt = w_to_req ? ST_REQ : ST_DONE;
                else if (out_ready) w_state_nxt = ST_IDLE;
            end
            ST_DRAIN: begin
                if (dm_data_ok) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_op     <= OP_NONE;
            r_addr   <= '0;
            r_wdata  <= 32'h0;
            r_result <= 32'h0;
            r_tag    <= '0;
            r_exc    <= EXC_NONE;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_op     <= in_op;
                r_addr   <= in_addr;
                r_wdata  <= in_wdata;
                r_tag    <= in_tag;
                r_exc    <= !w_fault ? EXC_NONE : (op_is_store(in_op) ? EXC_ADES : EXC_ADEL);
                r_result <= (in_op == OP_NONE) ? in_wdata : 32'h0;
            end else if (w_take_data) begin
                r_result <= w_rfmt;
            end
        end
    end

    assign dm_req       = (r_state == ST_REQ);
    assign dm_wr        = op_is_store(r_op);
    assign dm_wstrb     = w_wstrb;
    assign dm_addr      = {r_addr[ADDR_W-1:2], 2'b00};
    assign dm_wdata     = w_wlanes;
    assign out_valid    = (r_state == ST_DONE) && !flush;
    assign out_result   = r_result;
    assign out_tag      = r_tag;
    assign out_exc      = r_exc;
    assign out_badvaddr = r_addr;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Self-checking bench with memory responder and reference model.
// Revision : 1.0
// ============================================================================
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    localparam int TAG_W  = 64;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid, in_ready;
    logic [3:0]        in_op;
    logic [ADDR_W-1:0] in_addr;
    logic [31:0]       in_wdata;
    logic [TAG_W-1:0]  in_tag;
    logic              flush;
    logic              dm_req, dm_wr;
    logic [3:0]        dm_wstrb;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_wdata;
    logic              dm_addr_ok = 1'b0, dm_data_ok = 1'b0;
    logic [31:0]       dm_rdata = 32'h0;
    logic              out_valid, out_ready;
    logic [31:0]       out_result;
    logic [TAG_W-1:0]  out_tag;
    logic [4:0]        out_exc;
    logic [ADDR_W-1:0] out_badvaddr;

    mem_access_unit #(.TAG_W(TAG_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_addr(in_addr),
        .in_wdata(in_wdata), .in_tag(in_tag), .flush(flush),
        .dm_req(dm_req), .dm_wr(dm_wr), .dm_wstrb(dm_wstrb), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_addr_ok(dm_addr_ok), .dm_data_ok(dm_data_ok),
        .dm_rdata(dm_rdata), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag), .out_exc(out_exc),
        .out_badvaddr(out_badvaddr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int hs_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (!reset && out_valid && out_ready) hs_cnt <= hs_cnt + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- memory responder ----------------
    logic [31:0]       mem [0:8191];
    int                addr_delay = 0, data_delay = 0;
    int                a_wait = 0, d_cnt = 0;
    bit                d_pend = 0, cap_live = 0;
    int                req_cnt = 0;
    logic [ADDR_W-1:0] cap_addr;
    logic              cap_wr;
    logic [3:0]        cap_strb;
    logic [31:0]       cap_wdata, rd_word;

    always @(negedge clk) begin
        dm_addr_ok = 1'b0;
        dm_data_ok = 1'b0;
        if (reset) begin
            d_pend = 0; a_wait = 0; cap_live = 0;
        end else if (d_pend) begin
            chk("single_outstanding", dm_req, 1'b0);
            if (d_cnt == 0) begin
                dm_data_ok = 1'b1; dm_rdata = rd_word; d_pend = 0;
            end else d_cnt--;
        end else if (dm_req) begin
            if (!cap_live) begin
                cap_addr = dm_addr; cap_wr = dm_wr; cap_strb = dm_wstrb; cap_wdata = dm_wdata;
                cap_live = 1;
            end else begin
                chk("stable_addr", dm_addr, cap_addr);
                chk("stable_wr", dm_wr, cap_wr);
                chk("stable_strb", dm_wstrb, cap_strb);
                chk("stable_wdata", dm_wdata, cap_wdata);
            end
            if (a_wait == addr_delay) begin
                dm_addr_ok = 1'b1; req_cnt++; a_wait = 0; cap_live = 0;
                d_pend = 1; d_cnt = data_delay;
                if (cap_wr) begin
                    for (int b = 0; b < 4; b++)
                        if (cap_strb[b]) mem[cap_addr[14:2]][8*b +: 8] = cap_wdata[8*b +: 8];
                    rd_word = 32'h0;
                end else rd_word = mem[cap_addr[14:2]];
            end else a_wait++;
        end
    end

    // ---------------- reference model (byte-level) ----------------
    function automatic logic [4:0] ref_exc(input logic [3:0] op, input logic [31:0] a);
        if ((op == OP_LH || op == OP_LHU) && (a % 2 != 0)) return 5'd4;
        if (op == OP_SH && (a % 2 != 0)) return 5'd5;
        if (op == OP_LW && (a % 4 != 0)) return 5'd4;
        if (op == OP_SW && (a % 4 != 0)) return 5'd5;
        return 5'd0;
    endfunction

    function automatic bit ref_store(input logic [3:0] op);
        return op inside {OP_SB, OP_SH, OP_SW, OP_SWL, OP_SWR};
    endfunction

    function automatic bit ref_load(input logic [3:0] op);
        return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR};
    endfunction

    function automatic logic [31:0] ref_load_val(input logic [3:0] op, input logic [31:0] a,
                                                 input logic [31:0] memw, input logic [31:0] rt);
        logic [7:0]  m [4];
        logic [7:0]  r [4];
        logic [15:0] h;
        int k = int'(a % 4);
        for (int i = 0; i < 4; i++) begin
            m[i] = memw[8*i +: 8];
            r[i] = rt[8*i +: 8];
        end
        h = (k >= 2) ? {m[3], m[2]} : {m[1], m[0]};
        case (op)
            OP_LB:  return {{24{m[k][7]}}, m[k]};
            OP_LBU: return {24'h0, m[k]};
            OP_LH:  return {{16{h[15]}}, h};
            OP_LHU: return {16'h0, h};
            OP_LW:  return memw;
            OP_LWL: for (int i = 0; i <= k; i++) r[3-k+i] = m[i];
            OP_LWR: for (int i = k; i < 4; i++) r[i-k] = m[i];
            default: return 32'h0;
        endcase
        return {r[3], r[2], r[1], r[0]};
    endfunction

    task automatic ref_store_lanes(input logic [3:0] op, input logic [31:0] a, input logic [31:0] rt,
                                   output logic [3:0] strb, output logic [31:0] wd);
        logic [7:0] w [4];
        int k = int'(a % 4);
        strb = 4'b0;
        for (int i = 0; i < 4; i++) w[i] = 8'h0;
        for (int lane = 0; lane < 4; lane++) begin
            int src = -1;
            case (op)
                OP_SB:  if (lane == k) src = 0;
                OP_SH:  if (lane == k || lane == k + 1) src = lane - k;
                OP_SW:  src = lane;
                OP_SWL: if (lane <= k) src = 3 - k + lane;
                OP_SWR: if (lane >= k) src = lane - k;
                default: ;
            endcase
            if (src >= 0) begin
                strb[lane] = 1'b1;
                w[lane] = rt[8*src +: 8];
            end
        end
        wd = {w[3], w[2], w[1], w[0]};
    endtask

    // ---------------- transaction driver ----------------
    task automatic do_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [63:0] tag, input int stall_in,
                         output logic [31:0] res, output logic [4:0] exc,
                         output logic [31:0] bad, output logic [63:0] otag, output int lat);
        int acc_cyc, guard, stall;
        bit seen;
        res = '0; exc = '0; bad = '0; otag = '0; lat = -1; stall = stall_in;
        @(negedge clk);
        in_valid = 1; in_op = op; in_addr = addr; in_wdata = wd; in_tag = tag; out_ready = 0;
        #1;
        guard = 0;
        while (!in_ready && guard < 50) begin @(negedge clk); #1; guard++; end
        if (!in_ready) begin
            chk("accept_timeout", 1'b0, 1'b1);
            in_valid = 0;
            return;
        end
        acc_cyc = cyc;
        @(negedge clk);
        in_valid = 0;
        guard = 0; seen = 0;
        forever begin
            out_ready = (stall > 0) ? 1'b0 : 1'b1;
            #1;
            if (seen) chk("valid_held", out_valid, 1'b1);
            if (out_valid) begin
                if (!seen) lat = cyc - acc_cyc;
                seen = 1;
                if (out_ready) begin
                    res = out_result; exc = out_exc; bad = out_badvaddr; otag = out_tag;
                    break;
                end
                stall--;
            end
            guard++;
            if (guard > 200) begin chk("result_timeout", 1'b0, 1'b1); break; end
            @(negedge clk);
        end
        @(negedge clk);
        out_ready = 0;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr, wd, memw, res;
        logic [4:0]  exc;
        bit          req;
        logic [3:0]  strb;
        logic [31:0] dwd;
        int          lat;
    } vec_t;

    vec_t vt [14];

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] res, bad, memw, eres, ewd;
        logic [63:0] otag, tag;
        logic [4:0]  exc, eexc;
        logic [3:0]  op, estrb;
        logic [31:0] addr, wd;
        int          lat, r0, h0, guard, fcyc;
        bit          got;

        for (int i = 0; i < 8192; i++) mem[i] = 32'h0;
        reset = 1; in_valid = 0; in_op = OP_NONE; in_addr = '0; in_wdata = 0;
        in_tag = '0; flush = 0; out_ready = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_dm_req", dm_req, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_exc", out_exc, 5'd0);
        chk("rst_out_result", out_result, 32'h0);
        chk("rst_out_tag", out_tag, 64'h0);
        @(negedge clk);
        reset = 0;
        #1;
        chk("rst_in_ready", in_ready, 1'b1);

        // op, addr, wdata, mem word, result, exc, req, strb, dm_wdata, latency
        vt[0]  = '{OP_LB,   32'h1003, 32'h0,        32'h80FF_0000, 32'hFFFF_FF80, 5'd0, 1'b1, 4'h0, 32'h0,        3};
        vt[1]  = '{OP_SH,   32'h2002, 32'h0000_BEEF, 32'h0,        32'h0,         5'd0, 1'b1, 4'hC, 32'hBEEF_0000, 3};
        vt[2]  = '{OP_LW,   32'h3001, 32'h0,        32'h0,         32'h0,         5'd4, 1'b0, 4'h0, 32'h0,        1};
        vt[3]  = '{OP_SW,   32'h3001, 32'h1234_5678, 32'h0,        32'h0,         5'd5, 1'b0, 4'h0, 32'h0,        1};
        vt[4]  = '{OP_LWL,  32'h4001, 32'hAABB_CCDD, 32'h1122_3344, 32'h3344_CCDD, 5'd0, 1'b1, 4'h0, 32'h0,       3};
        vt[5]  = '{OP_LWR,  32'h4002, 32'hAABB_CCDD, 32'h1122_3344, 32'hAABB_1122, 5'd0, 1'b1, 4'h0, 32'h0,       3};
        vt[6]  = '{OP_NONE, 32'h5003, 32'hDEAD_BEEF, 32'h0,        32'hDEAD_BEEF, 5'd0, 1'b0, 4'h0, 32'h0,        1};
        vt[7]  = '{OP_LHU,  32'h6002, 32'h0,        32'h8001_7FFE, 32'h0000_8001, 5'd0, 1'b1, 4'h0, 32'h0,        3};
        vt[8]  = '{OP_LH,   32'h6002, 32'h0,        32'h8001_7FFE, 32'hFFFF_8001, 5'd0, 1'b1, 4'h0, 32'h0,        3};
        vt[9]  = '{OP_SWL,  32'h7001, 32'hA1B2_C3D4, 32'h0,        32'h0,         5'd0, 1'b1, 4'h3, 32'h0000_A1B2, 3};
        vt[10] = '{OP_SWR,  32'h7001, 32'hA1B2_C3D4, 32'h0,        32'h0,         5'd0, 1'b1, 4'hE, 32'hB2C3_D400, 3};
        vt[11] = '{OP_SB,   32'h7002, 32'h0000_00EE, 32'h0,        32'h0,         5'd0, 1'b1, 4'h4, 32'h00EE_0000, 3};
        vt[12] = '{OP_LH,   32'h6001, 32'h0,        32'h0,         32'h0,         5'd4, 1'b0, 4'h0, 32'h0,        1};
        vt[13] = '{OP_LBU,  32'h1003, 32'h0,        32'h80FF_0000, 32'h0000_0080, 5'd0, 1'b1, 4'h0, 32'h0,        3};

        addr_delay = 0; data_delay = 0;
        for (int i = 0; i < 14; i++) begin
            mem[vt[i].addr[14:2]] = vt[i].memw;
            r0 = req_cnt;
            tag = {32'hC0DE_0000, 32'(i)};
            do_op(vt[i].op, vt[i].addr, vt[i].wd, tag, 0, res, exc, bad, otag, lat);
            if (!ref_store(vt[i].op)) chk($sformatf("vec%0d_result", i), res, vt[i].res);
            chk($sformatf("vec%0d_exc", i), exc, vt[i].exc);
            chk($sformatf("vec%0d_tag", i), otag, tag);
            chk($sformatf("vec%0d_latency", i), lat, vt[i].lat);
            chk($sformatf("vec%0d_req_count", i), req_cnt - r0, vt[i].req ? 1 : 0);
            if (vt[i].exc != 0) chk($sformatf("vec%0d_badvaddr", i), bad, vt[i].addr);
            if (ref_store(vt[i].op) && vt[i].req) begin
                chk($sformatf("vec%0d_dm_wr", i), cap_wr, 1'b1);
                chk($sformatf("vec%0d_dm_wstrb", i), cap_strb, vt[i].strb);
                chk($sformatf("vec%0d_dm_wdata", i), cap_wdata, vt[i].dwd);
                chk($sformatf("vec%0d_dm_addr", i), cap_addr, vt[i].addr & 32'hFFFF_FFFC);
            end
        end

        // Slow memory plus a stalled consumer.
        addr_delay = 3; data_delay = 5;
        mem[32'h108 >> 2] = 32'hCAFE_F00D;
        r0 = req_cnt; h0 = hs_cnt;
        do_op(OP_LW, 32'h108, 32'h0, 64'h5107, 2, res, exc, bad, otag, lat);
        chk("slow_result", res, 32'hCAFE_F00D);
        chk("slow_latency", lat, 11);
        chk("slow_single_req", req_cnt - r0, 1);
        chk("slow_single_result", hs_cnt - h0, 1);

        // Flush while waiting for read data.
        addr_delay = 0; data_delay = 4;
        h0 = hs_cnt;
        @(negedge clk);
        in_valid = 1; in_op = OP_LW; in_addr = 32'h100; in_wdata = 0; in_tag = 64'hF1; out_ready = 1;
        #1;
        chk("flush_seq_ready", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 0;
        @(negedge clk);
        flush = 1;
        #1;
        chk("flush_in_ready_low", in_ready, 1'b0);
        fcyc = cyc;
        @(negedge clk);
        flush = 0; guard = 0; got = 0;
        while (guard < 20) begin
            flush = (guard == 1);
            #1;
            chk("drain_in_ready", in_ready, 1'b0);
            chk("drain_no_valid", out_valid, 1'b0);
            if (dm_data_ok) begin got = 1; break; end
            guard++;
            @(negedge clk);
        end
        flush = 0;
        chk("drain_data_ok_seen", got, 1'b1);
        chk("drain_data_ok_delay", cyc - fcyc, 4);
        @(negedge clk);
        #1;
        chk("after_drain_ready", in_ready, 1'b1);
        chk("after_drain_no_valid", out_valid, 1'b0);
        chk("flush_no_output", hs_cnt - h0, 0);

        // Flush coinciding with an offered op drops it.
        @(negedge clk);
        in_valid = 1; in_op = OP_LW; in_addr = 32'h104; flush = 1;
        #1;
        chk("flush_blocks_ready", in_ready, 1'b0);
        @(negedge clk);
        in_valid = 0; flush = 0;
        #1;
        chk("dropped_no_req", dm_req, 1'b0);
        chk("dropped_no_valid", out_valid, 1'b0);

        data_delay = 0;
        mem[32'h10C >> 2] = 32'h0BAD_CAFE;
        do_op(OP_LW, 32'h10C, 32'h0, 64'h77, 0, res, exc, bad, otag, lat);
        chk("post_flush_result", res, 32'h0BAD_CAFE);
        chk("post_flush_exc", exc, 5'd0);
        chk("post_flush_latency", lat, 3);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 300; n++) begin
            op   = 4'($urandom_range(0, 12));
            addr = 32'h100 + $urandom_range(0, 31);
            wd   = $urandom;
            tag  = {$urandom, $urandom};
            addr_delay = $urandom_range(0, 2);
            data_delay = $urandom_range(0, 2);
            memw = mem[addr[14:2]];
            eexc = ref_exc(op, addr);
            eres = (op == OP_NONE) ? wd : ref_load_val(op, addr, memw, wd);
            ref_store_lanes(op, addr, wd, estrb, ewd);
            r0 = req_cnt;
            do_op(op, addr, wd, tag, $urandom_range(0, 2), res, exc, bad, otag, lat);
            chk("rand_exc", exc, eexc);
            chk("rand_tag", otag, tag);
            chk("rand_req_count", req_cnt - r0, ((ref_load(op) || ref_store(op)) && eexc == 0) ? 1 : 0);
            if (eexc != 0) chk("rand_badvaddr", bad, addr);
            else if (!ref_store(op)) chk("rand_result", res, eres);
            else begin
                chk("rand_wstrb", cap_strb, estrb);
                chk("rand_wdata", cap_wdata, ewd);
                chk("rand_addr", cap_addr, addr & 32'hFFFF_FFFC);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
